cost_table: RTL and testbench

COST_TABLE -- requirements
Module: cost_table

---
 rtl/cost_table.sv | 92 +++++++++
 tb/tb_cost_table.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cost_table.sv
// cost_table: 8x8 cost matrix loaded row-major from a valid/ready stream.
// While loading, the minimum of each completed row is accumulated into
// LowerBound. After the 64th entry is accepted the table is frozen (READY)
// until a reload or reset. Cost is a combinational lookup of table[8*W+J].
//
// Handshake: in_ready is high only in LOAD with reload low. A word is
// accepted on a rising CLK edge where in_valid and in_ready are both high.
// reload wins over in_valid, and RST wins over everything.
module cost_table #(
   parameter int CW = 7,
   parameter int BW = 10
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          in_valid,
   input  logic [CW-1:0] in_data,
   output logic          in_ready,
   input  logic          reload,
   input  logic [2:0]    W,
   input  logic [2:0]    J,
   output logic [CW-1:0] Cost,
   output logic          table_ready,
   output logic [BW-1:0] LowerBound
);

   typedef enum logic {
      LOAD  = 1'b0,
      READY = 1'b1
   } state_t;

   state_t          state;
   logic [5:0]      idx;
   logic [CW-1:0]   rowmin;
   logic [CW-1:0]   tbl [64];
   logic            accept;
   logic [CW-1:0]   rowmin_next;

   // Ready to take a word only while loading and not being told to restart.
   assign in_ready = (state == LOAD) && !reload;
   assign accept   = in_valid && in_ready;

   // Lookup reads the stored array directly, so a word being written this
   // cycle still shows its old value until the edge.
   assign Cost = tbl[{W, J}];

   // Running row minimum including the incoming word; column 0 restarts it.
   always_comb begin
      rowmin_next = in_data;
      if (idx[2:0] != 3'd0 && rowmin < in_data) begin
         rowmin_next = rowmin;
      end
   end

   // Table storage: cleared by reset, written only by accepts (reload keeps it).
   always_ff @(posedge CLK) begin
      if (!RST) begin
         for (int i = 0; i < 64; i++) begin
            tbl[i] <= '0;
         end
      end else if (accept) begin
         tbl[idx] <= in_data;
      end
   end

   // Control FSM: load index, row minimum, lower bound and ready flag.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state       <= LOAD;
         idx         <= '0;
         rowmin      <= '0;
         LowerBound  <= '0;
         table_ready <= 1'b0;
      end else if (reload) begin
         state       <= LOAD;
         idx         <= '0;
         rowmin      <= '0;
         LowerBound  <= '0;
         table_ready <= 1'b0;
      end else if (accept) begin
         idx    <= idx + 6'd1;
         rowmin <= rowmin_next;
         if (idx[2:0] == 3'd7) begin
            LowerBound <= LowerBound + {{(BW-CW){1'b0}}, rowmin_next};
         end
         if (idx == 6'd63) begin
            state       <= READY;
            table_ready <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cost_table.sv
// tb_cost_table: directed stimulus for cost_table. A reference model tracks
// the accepted words of the current load and derives the lower bound as the
// sum of the minima of the completed rows; a negedge process compares every
// output against it, and literal expectations pin the headline numbers.
module tb_cost_table;

   localparam int CW = 7;
   localparam int BW = 10;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [CW-1:0] in_data;
   logic          in_ready;
   logic          reload;
   logic [2:0]    W;
   logic [2:0]    J;
   logic [CW-1:0] Cost;
   logic          table_ready;
   logic [BW-1:0] LowerBound;

   int n_checks = 0;
   int n_errors = 0;

   cost_table #(.CW(CW), .BW(BW)) dut (
      .CLK(clk),
      .RST(rst),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .reload(reload),
      .W(W),
      .J(J),
      .Cost(Cost),
      .table_ready(table_ready),
      .LowerBound(LowerBound)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int m_tab  [64];
   int m_vals [64];
   int m_cnt   = 0;
   bit m_ready = 1'b0;
   bit m_valid = 1'b0;

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 64; i++) m_tab[i] = 0;
         m_cnt   = 0;
         m_ready = 1'b0;
         m_valid = 1'b1;
      end else if (reload) begin
         m_cnt   = 0;
         m_ready = 1'b0;
      end else if (!m_ready && in_valid) begin
         m_tab[m_cnt]  = int'(in_data);
         m_vals[m_cnt] = int'(in_data);
         m_cnt++;
         if (m_cnt == 64) m_ready = 1'b1;
      end
   end

   function automatic int model_lb();
      int s;
      int mn;
      s = 0;
      for (int r = 0; r < m_cnt / 8; r++) begin
         mn = 1 << 30;
         for (int c = 0; c < 8; c++) begin
            if (m_vals[8*r+c] < mn) mn = m_vals[8*r+c];
         end
         s += mn;
      end
      return s;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (m_valid && rst) begin
         chk("cmp_in_ready", {31'd0, in_ready}, {31'd0, (!m_ready && !reload)});
         chk("cmp_table_ready", {31'd0, table_ready}, {31'd0, m_ready});
         chk("cmp_lower_bound", {22'd0, LowerBound}, model_lb());
         chk("cmp_cost", {25'd0, Cost}, m_tab[{W, J}]);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      step();
      reload = 1'b0;
   endtask

   // pat < 0 streams k mod 100, otherwise the constant pat.
   task automatic load_all(input int pat, input bit bubbles);
      for (int k = 0; k < 64; k++) begin
         in_valid = 1'b1;
         in_data  = (pat < 0) ? 7'(k % 100) : 7'(pat);
         W = 3'(k % 8);
         J = 3'((k * 3) % 8);
         step();
         if (!bubbles) chk("tr_rise", {31'd0, table_ready}, {31'd0, (k == 63)});
         if (bubbles) begin
            in_valid = 1'b0;
            step();
            chk("bubble_tr", {31'd0, table_ready}, {31'd0, (k == 63)});
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic load_part(input int n, input int val);
      for (int k = 0; k < n; k++) begin
         in_valid = 1'b1;
         in_data  = 7'(val);
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic peek(input string name, input int wi, input int ji, input int exp);
      W = 3'(wi);
      J = 3'(ji);
      #1;
      chk(name, {25'd0, Cost}, exp);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b0; in_valid = 1'b0; in_data = '0; reload = 1'b0; W = '0; J = '0;
      step();
      step();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b1;
      chk("rst_lb", {22'd0, LowerBound}, 32'd0);
      chk("rst_tr", {31'd0, table_ready}, 32'd0);
      peek("rst_cost", 5, 2, 0);

      // Full load without bubbles.
      load_all(-1, 1'b0);
      chk("full_lb", {22'd0, LowerBound}, 32'd224);
      peek("full_cost_3_5", 3, 5, 29);

      // READY ignores further data.
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         in_data  = 7'd99;
         #1;
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         step();
      end
      in_valid = 1'b0;
      chk("hold_lb", {22'd0, LowerBound}, 32'd224);
      for (int k = 0; k < 64; k++) begin
         W = 3'(k / 8);
         J = 3'(k % 8);
         step();
         chk("sweep_cost", {25'd0, Cost}, k);
      end

      // Same data with bubbles.
      pulse_reload();
      chk("reload_tr", {31'd0, table_ready}, 32'd0);
      load_all(-1, 1'b1);
      chk("bubble_lb", {22'd0, LowerBound}, 32'd224);

      // Extremes.
      pulse_reload();
      load_all(127, 1'b0);
      chk("max_lb", {22'd0, LowerBound}, 32'd1016);
      pulse_reload();
      load_all(0, 1'b0);
      chk("zero_lb", {22'd0, LowerBound}, 32'd0);

      // Reload mid-row at idx 13.
      pulse_reload();
      load_all(-1, 1'b0);
      pulse_reload();
      load_part(13, 5);
      chk("mid_lb_row0", {22'd0, LowerBound}, 32'd5);
      reload = 1'b1; in_valid = 1'b1; in_data = 7'd77;
      #1;
      chk("mid_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      reload = 1'b0; in_valid = 1'b0;
      chk("mid_lb", {22'd0, LowerBound}, 32'd0);
      chk("mid_tr", {31'd0, table_ready}, 32'd0);
      peek("mid_keep_0_4", 0, 4, 5);
      peek("mid_keep_1_4", 1, 4, 5);
      peek("mid_no_write", 1, 5, 13);
      load_part(1, 9);
      peek("mid_restart_0_0", 0, 0, 9);
      peek("mid_restart_0_1", 0, 1, 5);

      // Reset mid-load at idx 40.
      pulse_reload();
      load_part(40, 3);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("rstmid_lb", {22'd0, LowerBound}, 32'd0);
      chk("rstmid_tr", {31'd0, table_ready}, 32'd0);
      for (int k = 0; k < 64; k++) begin
         W = 3'(k / 8);
         J = 3'(k % 8);
         step();
         chk("rstmid_cost", {25'd0, Cost}, 32'd0);
      end
      load_all(-1, 1'b0);
      chk("fresh_lb", {22'd0, LowerBound}, 32'd224);
      peek("fresh_cost_7_7", 7, 7, 63);
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
